// File: rtl/apb_master_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : Single-outstanding command/response port to APB requester, with
//            an optional ACCESS-phase wait timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic          cmd_write,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [SW-1:0] cmd_strb,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_slverr,
    output logic          rsp_timeout,

    output logic          PSEL,
    output logic          PENABLE,
    output logic [AW-1:0] PADDR,
    output logic [2:0]    PPROT,
    output logic          PNSE,
    output logic          PWRITE,
    output logic [DW-1:0] PWDATA,
    output logic [SW-1:0] PSTRB,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    // The counter only needs to reach TIMEOUT-1: the abort fires on the stall
    // cycle that would take it to TIMEOUT.
    localparam int              c_WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic            c_TO_EN     = (TIMEOUT > 0);
    localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]      r_state;
    logic            r_cmd_ready;
    logic            r_psel;
    logic            r_penable;
    logic [AW-1:0]   r_paddr;
    logic            r_pwrite;
    logic [DW-1:0]   r_pwdata;
    logic [SW-1:0]   r_pstrb;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_rdata;
    logic            r_rsp_slverr;
    logic            r_rsp_timeout;
    logic [c_WW-1:0] r_wait;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state       <= c_ST_IDLE;
            r_cmd_ready   <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_wait        <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_cmd_ready && cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_paddr     <= cmd_addr;
                        r_pwrite    <= cmd_write;
                        r_pwdata    <= cmd_write ? cmd_wdata : '0;
                        r_pstrb     <= cmd_write ? cmd_strb  : '0;
                        r_state     <= c_ST_SETUP;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                c_ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                    r_state   <= c_ST_ACCESS;
                end

                c_ST_ACCESS: begin
                    // A completing PREADY wins over a timeout in the same cycle.
                    if (PREADY) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
                        r_rsp_slverr  <= PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= c_ST_RESP;
                    end else if (c_TO_EN && (r_wait == c_WAIT_LAST)) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_slverr  <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= c_ST_RESP;
                    end else if (c_TO_EN) begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

                c_ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_slverr  = r_rsp_slverr;
    assign rsp_timeout = r_rsp_timeout;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PADDR       = r_paddr;
    assign PPROT       = 3'b000;
    assign PNSE        = 1'b0;
    assign PWRITE      = r_pwrite;
    assign PWDATA      = r_pwdata;
    assign PSTRB       = r_pstrb;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Purpose  : Randomised scoreboard bench for apb_master_bridge with a memory
//            completer model and an abstract command-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int c_TIMEOUT = 16;
    localparam int c_STALL   = 1000;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          w;
    } cmd_t;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
        int          lat;
    } exp_t;

    logic        PCLK      = 1'b0;
    logic        PRESETn   = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr  = '0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb  = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic [2:0]  PPROT;
    logic        PNSE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA    = '0;
    logic        PREADY    = 1'b0;
    logic        PSLVERR   = 1'b0;

    cmd_t        cq[$];
    exp_t        sbq[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] cpl_mem [logic [31:0]];
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          rr_mode = 0;

    apb_master_bridge #(
        .AW      (32),
        .DW      (32),
        .SW      (4),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_write   (cmd_write),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PADDR       (PADDR),
        .PPROT       (PPROT),
        .PNSE        (PNSE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] errval(input logic [31:0] a);
        return {16'hBAD0, a[15:0]};
    endfunction

    function automatic logic is_err(input logic [31:0] a);
        return a[31:16] == 16'h4002;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred that the model does not allow (cycle %0d)", name, cyc);
    endtask

    // Command-level model: a transfer stalled for TIMEOUT or more cycles is
    // aborted and has no effect; otherwise it behaves as a plain memory access.
    task automatic issue_ref(input cmd_t c);
        exp_t        e;
        logic [31:0] cur;
        if (c.w >= c_TIMEOUT) begin
            e.rdata = '0; e.slverr = 1'b1; e.timeout = 1'b1; e.lat = c_TIMEOUT + 2;
        end else begin
            e.lat = 3 + c.w; e.timeout = 1'b0; e.slverr = is_err(c.addr); e.rdata = '0;
            cur = ref_mem.exists(c.addr) ? ref_mem[c.addr] : dflt(c.addr);
            if (c.write) begin
                if (!is_err(c.addr)) ref_mem[c.addr] = merge(cur, c.wdata, c.strb);
            end else begin
                e.rdata = is_err(c.addr) ? errval(c.addr) : cur;
            end
        end
        sbq.push_back(e);
        cq.push_back(c);
    endtask

    task automatic send(input logic [31:0] a, input logic wr, input logic [31:0] d,
                        input logic [3:0] s, input int w);
        cmd_t c;
        logic ok;
        c.addr = a; c.write = wr; c.wdata = d; c.strb = s; c.w = w;
        issue_ref(c);
        ok = 1'b0;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = wr; cmd_wdata = d; cmd_strb = s;
        for (int i = 0; i < 300; i++) begin
            @(negedge PCLK);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("cmd_accepted", ok, 1'b1);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 600; i++) begin
            @(negedge PCLK);
            if (sbq.size() == 0) break;
        end
        chk("scoreboard_drained", sbq.size(), 0);
    endtask

    // Response monitor: latency, stability while stalled, and field values.
    initial begin : mon
        logic        seen;
        exp_t        e;
        logic [31:0] s_rdata;
        logic        s_err;
        logic        s_to;
        int          hsq[$];
        seen = 1'b0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                seen = 1'b0;
                hsq.delete();
            end else begin
                if (cmd_valid && cmd_ready) hsq.push_back(cyc);
                if (rsp_valid) begin
                    chk("cmd_ready_low_in_resp", cmd_ready, 1'b0);
                    if (!seen) begin
                        seen = 1'b1;
                        s_rdata = rsp_rdata; s_err = rsp_slverr; s_to = rsp_timeout;
                        if (hsq.size() == 0) fail("rsp_without_cmd");
                        else chk("rsp_latency", cyc - hsq.pop_front(),
                                 (sbq.size() != 0) ? sbq[0].lat : -1);
                    end else begin
                        chk("rsp_stable", {rsp_rdata, rsp_slverr, rsp_timeout},
                            {s_rdata, s_err, s_to});
                    end
                    if (rsp_ready) begin
                        seen = 1'b0;
                        if (sbq.size() == 0) fail("unexpected_rsp");
                        else begin
                            e = sbq.pop_front();
                            chk("rsp_rdata",   rsp_rdata,   e.rdata);
                            chk("rsp_slverr",  rsp_slverr,  e.slverr);
                            chk("rsp_timeout", rsp_timeout, e.timeout);
                        end
                    end
                end
            end
        end
    end

    // APB completer: memory with an error region, per-command wait counts.
    initial begin : cpl
        cmd_t        c;
        int          acc;
        logic        active;
        logic        done;
        logic        exp_acc;
        logic [31:0] cur;
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        acc = 0; active = 1'b0; done = 1'b0; exp_acc = 1'b0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                active = 1'b0; exp_acc = 1'b0; PREADY = 1'b0;
            end else begin
                if (exp_acc) chk("psel_penable_11_after_10", {PSEL, PENABLE}, 2'b11);
                exp_acc = 1'b0;
                if (active && !PSEL) begin
                    if (!done) chk("abort_after_access_cycles", acc, c_TIMEOUT);
                    active = 1'b0;
                end
                PREADY  = 1'($urandom_range(0, 1));
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
                if (PSEL && !PENABLE) begin
                    if (cq.size() == 0) fail("unexpected_setup");
                    else begin
                        c = cq.pop_front();
                        active = 1'b1; done = 1'b0; acc = 0; exp_acc = 1'b1;
                        exp_wd = c.write ? c.wdata : 32'h0;
                        exp_st = c.write ? c.strb  : 4'h0;
                        chk("setup_bus", {PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE},
                            {c.addr, c.write, exp_wd, exp_st, 3'b000, 1'b0});
                    end
                end else if (PSEL && PENABLE && active) begin
                    acc++;
                    chk("access_bus_stable", {PADDR, PWRITE, PWDATA, PSTRB},
                        {c.addr, c.write, exp_wd, exp_st});
                    if (acc > c.w) begin
                        PREADY = 1'b1;
                        done   = 1'b1;
                        if (is_err(c.addr)) begin
                            PSLVERR = 1'b1;
                            if (!c.write) PRDATA = errval(c.addr);
                        end else begin
                            PSLVERR = 1'b0;
                            cur = cpl_mem.exists(c.addr) ? cpl_mem[c.addr] : dflt(c.addr);
                            if (c.write) cpl_mem[c.addr] = merge(cur, PWDATA, PSTRB);
                            else PRDATA = cur;
                        end
                    end else begin
                        PREADY = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : rr_drv
        int hold;
        hold = 0;
        forever begin
            @(posedge PCLK); #1;
            case (rr_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (rsp_valid) begin
                        rsp_ready = (hold >= 5);
                        hold++;
                    end else begin
                        rsp_ready = 1'b0;
                        hold = 0;
                    end
                end
            endcase
        end
    end

    initial begin : watchdog
        #500000;
        errors++;
        checks++;
        $display("FAIL watchdog: actual cycle %0d required completion before it", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] a;
        logic        wr;
        logic [3:0]  s;
        int          w;
        int          vis;
        int          sel;

        ref_mem[32'h4000_100C] = 32'hA735_0001;
        cpl_mem[32'h4000_100C] = 32'hA735_0001;

        repeat (3) @(negedge PCLK);
        chk("reset_rsp_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout}, '0);
        chk("reset_apb_outputs", {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE}, '0);
        #2 PRESETn = 1'b1;
        @(posedge PCLK); #1;
        chk("cmd_ready_after_release", cmd_ready, 1'b1);

        rr_mode = 0;
        send(32'h4000_1010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0);
        send(32'h4000_1010, 1'b0, 32'h1234_5678, 4'hF, 0);
        send(32'h4000_100C, 1'b0, 32'hFFFF_FFFF, 4'hF, 0);
        send(32'h4002_0000, 1'b0, 32'h0,         4'h0, 0);
        send(32'h4002_0004, 1'b1, 32'h5555_AAAA, 4'hF, 1);
        send(32'h4000_1014, 1'b1, 32'h1122_3344, 4'b0101, 2);
        send(32'h4000_1014, 1'b0, 32'h0,         4'h0, 3);
        wait_drain();

        send(32'h4000_1018, 1'b0, 32'h0,         4'h0, c_TIMEOUT - 1);
        send(32'h4000_1018, 1'b0, 32'h0,         4'h0, c_TIMEOUT);
        send(32'h4000_1010, 1'b1, 32'h0BAD_F00D, 4'hF, c_STALL);
        send(32'h4000_1010, 1'b0, 32'h0,         4'h0, 0);
        wait_drain();

        rr_mode = 2;
        send(32'h4000_1004, 1'b1, 32'hCAFE_0001, 4'hF, 0);
        send(32'h4000_1004, 1'b0, 32'h0,         4'h0, 1);
        send(32'h4002_0008, 1'b0, 32'h0,         4'h0, 0);
        wait_drain();

        rr_mode = 1;
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 7);
            a   = (sel == 0) ? (32'h4002_0000 + 32'(4 * $urandom_range(0, 3)))
                             : (32'h4000_1000 + 32'(4 * $urandom_range(0, 7)));
            wr  = 1'($urandom_range(0, 1));
            s   = 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 19);
            w   = (sel == 0) ? c_STALL : (sel == 1) ? c_TIMEOUT - 1 : $urandom_range(0, 3);
            send(a, wr, $urandom, s, w);
            repeat ($urandom_range(0, 3)) @(posedge PCLK);
        end
        wait_drain();

        rr_mode = 0;
        send(32'h4000_1000, 1'b0, 32'h0, 4'h0, c_STALL);
        for (int i = 0; i < 50; i++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE) break;
        end
        chk("reached_access", {PSEL, PENABLE}, 2'b11);
        repeat (3) @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1 chk("async_reset_outputs", {PSEL, PENABLE, cmd_ready, rsp_valid}, 4'b0000);
        sbq.delete();
        cq.delete();
        repeat (2) @(negedge PCLK);
        #2 PRESETn = 1'b1;
        vis = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (rsp_valid) vis++;
        end
        chk("no_rsp_after_reset", vis, 0);
        chk("cmd_ready_idle_after_reset", cmd_ready, 1'b1);

        send(32'h4000_1010, 1'b0, 32'h0, 4'h0, 0);
        send(32'h4000_100C, 1'b0, 32'h0, 4'h0, 0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
